// File: rtl/hpdcache_victim_cyclic_set_if.sv
// Victim-selection request/response bundle for the cyclic victim selector.
interface hpdcache_victim_cyclic_set_if #(
  parameter int unsigned Sets = 4,
  parameter int unsigned Ways = 4
);
  localparam int unsigned SetW = (Sets > 1) ? $clog2(Sets) : 1;

  logic              updt_i;
  logic [SetW-1:0]   updt_set_i;
  logic [Ways-1:0]   updt_way_i;
  logic              sel_victim_i;
  logic [Ways-1:0]   sel_dir_valid_i;
  logic [Ways-1:0]   sel_dir_wback_i;
  logic [Ways-1:0]   sel_dir_dirty_i;
  logic [Ways-1:0]   sel_dir_fetch_i;
  logic [SetW-1:0]   sel_victim_set_i;
  logic              cfg_skip_dirty_i;
  logic              cfg_hit_protect_i;
  logic              ptr_clr_i;
  logic [Ways-1:0]   sel_victim_way_o;

  modport master (
    output updt_i, updt_set_i, updt_way_i, sel_victim_i, sel_dir_valid_i, sel_dir_wback_i,
           sel_dir_dirty_i, sel_dir_fetch_i, sel_victim_set_i, cfg_skip_dirty_i,
           cfg_hit_protect_i, ptr_clr_i,
    input  sel_victim_way_o
  );

  modport slave (
    input  updt_i, updt_set_i, updt_way_i, sel_victim_i, sel_dir_valid_i, sel_dir_wback_i,
           sel_dir_dirty_i, sel_dir_fetch_i, sel_victim_set_i, cfg_skip_dirty_i,
           cfg_hit_protect_i, ptr_clr_i,
    output sel_victim_way_o
  );
endinterface

// File: rtl/hpdcache_victim_cyclic_set.sv
// Cyclic (round-robin) victim selector with per-set or global wrap-around pointers,
// optional clean-first preference and hit-protect pointer advance.
package hpdcache_victim_cyclic_set_pkg;
  typedef struct packed {
    int unsigned sets;
    int unsigned ways;
  } hpdcache_user_cfg_t;

  typedef struct packed {
    hpdcache_user_cfg_t u;
    int unsigned        wayIndexWidth;
  } hpdcache_cfg_t;

  localparam hpdcache_cfg_t HPDcacheCfgDefault = '{
    u: '{sets: 32'd4, ways: 32'd4},
    wayIndexWidth: 32'd2
  };
endpackage

module hpdcache_victim_cyclic_set
  import hpdcache_victim_cyclic_set_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg = HPDcacheCfgDefault,
  parameter bit            PerSetPtr   = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  hpdcache_victim_cyclic_set_if.slave  bus_io
);
  localparam int unsigned Ways    = HPDcacheCfg.u.ways;
  localparam int unsigned Sets    = HPDcacheCfg.u.sets;
  localparam int unsigned WayIdxW = HPDcacheCfg.wayIndexWidth;
  localparam int unsigned NumPtrs = PerSetPtr ? Sets : 1;
  localparam int unsigned PtrIdxW = (NumPtrs > 1) ? $clog2(NumPtrs) : 1;

  typedef logic [WayIdxW-1:0] way_idx_t;
  typedef logic [PtrIdxW-1:0] ptr_idx_t;

  // Increment with explicit wrap so non-power-of-2 way counts stay in range.
  function automatic way_idx_t wrap_inc(input way_idx_t x);
    return (32'(x) == Ways - 1) ? '0 : x + way_idx_t'(1);
  endfunction

  // First set bit of vec searching p, p+1, ..., Ways-1, 0, ..., p-1; MSB of result = found.
  function automatic logic [WayIdxW:0] circ_first(input logic [Ways-1:0] vec, input way_idx_t p);
    logic        found;
    way_idx_t    idx;
    way_idx_t    idx_j;
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < Ways; k++) begin
      j = 32'(p) + k;
      if (j >= Ways) j = j - Ways;
      idx_j = way_idx_t'(j);
      if (!found && vec[idx_j]) begin
        found = 1'b1;
        idx   = idx_j;
      end
    end
    return {found, idx};
  endfunction

  way_idx_t ptr_q [NumPtrs];
  way_idx_t ptr_d [NumPtrs];

  logic [Ways-1:0]  unused_ways, cand_ways, clean_ways;
  logic [WayIdxW:0] search;
  way_idx_t         sel_ptr, victim_idx, updt_idx;
  logic             victim_rot;
  ptr_idx_t         sel_pidx, updt_pidx;
  logic             unused_wback;

  assign unused_wback = ^bus_io.sel_dir_wback_i;

  assign sel_pidx  = PerSetPtr ? ptr_idx_t'(bus_io.sel_victim_set_i) : '0;
  assign updt_pidx = PerSetPtr ? ptr_idx_t'(bus_io.updt_set_i) : '0;
  assign sel_ptr   = ptr_q[sel_pidx];

  assign unused_ways = ~bus_io.sel_dir_fetch_i & ~bus_io.sel_dir_valid_i;
  assign cand_ways   = ~bus_io.sel_dir_fetch_i & bus_io.sel_dir_valid_i;
  assign clean_ways  = cand_ways & ~bus_io.sel_dir_dirty_i;

  // Victim priority: unused (lowest index), then clean-first, then any candidate.
  always_comb begin
    search     = '0;
    victim_rot = 1'b0;
    if (|unused_ways) begin
      search = circ_first(unused_ways, '0);
    end else if (bus_io.cfg_skip_dirty_i && |clean_ways) begin
      search     = circ_first(clean_ways, sel_ptr);
      victim_rot = 1'b1;
    end else if (|cand_ways) begin
      search     = circ_first(cand_ways, sel_ptr);
      victim_rot = 1'b1;
    end
    victim_idx = search[WayIdxW-1:0];
    bus_io.sel_victim_way_o = search[WayIdxW] ? (Ways'(1) << victim_idx) : '0;
  end

  // Index of the (assumed one-hot) accessed way.
  always_comb begin
    updt_idx = '0;
    for (int unsigned k = 0; k < Ways; k++) begin
      if (bus_io.updt_way_i[way_idx_t'(k)]) updt_idx = updt_idx | way_idx_t'(k);
    end
  end

  // Pointer next state; the selection commit is applied last so it wins on a shared entry.
  always_comb begin
    ptr_d = ptr_q;
    if (bus_io.ptr_clr_i) begin
      for (int unsigned s = 0; s < NumPtrs; s++) ptr_d[s] = '0;
    end else begin
      if (bus_io.updt_i && bus_io.cfg_hit_protect_i && |bus_io.updt_way_i &&
          (updt_idx == ptr_q[updt_pidx])) begin
        ptr_d[updt_pidx] = wrap_inc(ptr_q[updt_pidx]);
      end
      if (bus_io.sel_victim_i && victim_rot) begin
        ptr_d[sel_pidx] = wrap_inc(victim_idx);
      end
    end
  end

  // Pointer state with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NumPtrs; s++) ptr_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < NumPtrs; s++) ptr_q[s] <= ptr_d[s];
    end
  end
endmodule

// File: tb/tb_hpdcache_victim_cyclic_set.sv
// Scoreboard bench for the cyclic victim selector: 4 ways, 4 sets, per-set pointers.
module tb_hpdcache_victim_cyclic_set;
  import hpdcache_victim_cyclic_set_pkg::*;

  localparam hpdcache_cfg_t Cfg = '{u: '{sets: 32'd4, ways: 32'd4}, wayIndexWidth: 32'd2};
  localparam logic [3:0] AllV = 4'b1111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [3:0] exp_q[$];
  string      tag_q[$];

  hpdcache_victim_cyclic_set_if #(.Sets(4), .Ways(4)) bus ();

  hpdcache_victim_cyclic_set #(
    .HPDcacheCfg (Cfg),
    .PerSetPtr   (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic expect_victim(input string tag, input logic [3:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Wait for the combinational output to settle, then drain the scoreboard.
  task automatic settle(input int dly);
    #(dly);
    while (exp_q.size() > 0) check_eq(tag_q.pop_front(), bus.sel_victim_way_o, exp_q.pop_front());
  endtask

  // One cycle: drive selection inputs, check the victim before the edge, pulse-type inputs drop.
  task automatic cyc(input string tag, input logic [1:0] set, input logic sel,
                     input logic [3:0] valid, input logic [3:0] dirty, input logic [3:0] fetch,
                     input logic [3:0] exp);
    bus.sel_victim_set_i = set;
    bus.sel_victim_i     = sel;
    bus.sel_dir_valid_i  = valid;
    bus.sel_dir_dirty_i  = dirty;
    bus.sel_dir_fetch_i  = fetch;
    expect_victim(tag, exp);
    settle(2);
    @(negedge clk);
    bus.updt_i    = 1'b0;
    bus.ptr_clr_i = 1'b0;
    bus.sel_victim_i = 1'b0;
  endtask

  // Pure cyclic probe with everything eligible: the victim is one-hot of the pointer.
  task automatic probe(input string tag, input logic [1:0] set, input logic [3:0] exp);
    cyc(tag, set, 1'b0, AllV, 4'b0000, 4'b0000, exp);
  endtask

  // Drive a pointer to k by committing with only way k-1 (mod 4) eligible.
  task automatic set_ptr(input logic [1:0] set, input int k);
    logic [3:0] w;
    w = 4'b0001 << ((k + 3) % 4);
    cyc("set_ptr", set, 1'b1, AllV, 4'b0000, ~w, w);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.updt_i = 1'b0;
    bus.updt_set_i = '0;
    bus.updt_way_i = '0;
    bus.sel_victim_i = 1'b0;
    bus.sel_dir_valid_i = '0;
    bus.sel_dir_wback_i = '0;
    bus.sel_dir_dirty_i = '0;
    bus.sel_dir_fetch_i = '0;
    bus.sel_victim_set_i = '0;
    bus.cfg_skip_dirty_i = 1'b0;
    bus.cfg_hit_protect_i = 1'b0;
    bus.ptr_clr_i = 1'b0;
    @(negedge clk);
    cyc("in_reset", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0001);
    rst_n = 1'b1;

    // Rotation on set 2 with wrap 3->0.
    cyc("rot0", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0001);
    cyc("rot1", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0010);
    cyc("rot2", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0100);
    cyc("rot3", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b1000);
    cyc("rot4", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0001);
    probe("set1_ptr0", 2'd1, 4'b0001);
    probe("set2_ptr1", 2'd2, 4'b0010);

    // Unused way wins and the pointer is left alone.
    cyc("unused", 2'd0, 1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0100);
    probe("unused_ptr0", 2'd0, 4'b0001);

    // Fetching ways skipped with circular wrap.
    set_ptr(2'd1, 3);
    cyc("fetch_wrap", 2'd1, 1'b1, AllV, 4'b0000, 4'b1001, 4'b0010);
    probe("fetch_ptr2", 2'd1, 4'b0100);
    cyc("fetch_all", 2'd1, 1'b1, AllV, 4'b0000, 4'b1111, 4'b0000);
    probe("fetch_all_ptr", 2'd1, 4'b0100);

    // Clean-first preference.
    set_ptr(2'd3, 1);
    bus.cfg_skip_dirty_i = 1'b1;
    cyc("clean_first", 2'd3, 1'b0, AllV, 4'b0110, 4'b0000, 4'b1000);
    cyc("all_dirty", 2'd3, 1'b0, AllV, 4'b1111, 4'b0000, 4'b0010);
    bus.cfg_skip_dirty_i = 1'b0;
    cyc("pure_cyclic", 2'd3, 1'b0, AllV, 4'b0110, 4'b0000, 4'b0010);

    // Hit-protect advance.
    set_ptr(2'd0, 2);
    bus.cfg_hit_protect_i = 1'b1;
    bus.updt_i = 1'b1; bus.updt_set_i = 2'd0; bus.updt_way_i = 4'b0100;
    probe("hp_same_cycle", 2'd0, 4'b0100);
    probe("hp_advanced", 2'd0, 4'b1000);
    set_ptr(2'd0, 2);
    bus.cfg_hit_protect_i = 1'b0;
    bus.updt_i = 1'b1; bus.updt_set_i = 2'd0; bus.updt_way_i = 4'b0100;
    probe("hp_off_cycle", 2'd0, 4'b0100);
    probe("hp_off_ptr", 2'd0, 4'b0100);
    bus.cfg_hit_protect_i = 1'b1;
    bus.updt_i = 1'b1; bus.updt_set_i = 2'd0; bus.updt_way_i = 4'b0100;
    cyc("hp_vs_sel", 2'd0, 1'b1, AllV, 4'b0000, 4'b1101, 4'b0010);
    probe("sel_wins", 2'd0, 4'b0100);
    bus.updt_i = 1'b1; bus.updt_set_i = 2'd1; bus.updt_way_i = 4'b0100;
    cyc("sel_other_set", 2'd0, 1'b1, AllV, 4'b0000, 4'b1011, 4'b0100);
    probe("sel_set0_ptr3", 2'd0, 4'b1000);
    probe("hp_set1_ptr3", 2'd1, 4'b1000);
    bus.cfg_hit_protect_i = 1'b0;

    // Synchronous clear beats a simultaneous commit.
    bus.ptr_clr_i = 1'b1;
    cyc("clr_cycle", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0010);
    for (int s = 0; s < 4; s++) probe($sformatf("clr_set%0d", s), 2'(s), 4'b0001);

    // Asynchronous reset mid-cycle.
    cyc("pre_rst_commit", 2'd2, 1'b1, AllV, 4'b0000, 4'b0000, 4'b0001);
    bus.sel_victim_set_i = 2'd2;
    bus.sel_dir_valid_i  = AllV;
    bus.sel_dir_dirty_i  = '0;
    bus.sel_dir_fetch_i  = '0;
    expect_victim("pre_rst", 4'b0010);
    settle(2);
    rst_n = 1'b0;
    expect_victim("async_rst", 4'b0001);
    settle(1);
    @(negedge clk);
    rst_n = 1'b1;
    probe("post_rst", 2'd2, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
